sha3_padder: RTL
================

Name: sha3_padder

Overview:
- Upstream feeder of the SHA3-256 core (SHA3TOP).
- Accepts a message as a 64-bit little-endian word stream and assembles 1088-bit rate blocks.
- Applies SHA-3 pad10*1 with the domain byte, then hands each block to the core using the core's in/more/in_valid protocol.
- Paces block delivery on the core's hash_next (ready for the next block) and out_valid (digest done) signals.

Parameters:
- RATE_BYTES, 136, rate in bytes. Must be a multiple of 8. Use 144/136/104/72 for SHA3-224/256/384/512.
- DOMAIN, 8'h06, domain-separation byte. Use 8'h1F for SHAKE.
- RATE_WORDS, RATE_BYTES/8, derived; do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  64  message word; byte i at bits [8i+7:8i], earlier bytes in lower bits.
- in_valid  input  1  word valid.
- in_last  input  1  word is the final word of the message.
- in_bytes  input  4  valid bytes in the last word, 0..8; ignored when in_last=0.
- in_ready  output  1  padder accepts a word this cycle.
- blk_data  output  8*RATE_BYTES  rate block; connects to the core's in.
- blk_valid  output  1  one-cycle block strobe; connects to the core's in_valid.
- blk_more  output  1  1 = more blocks follow; 0 = final block; connects to the core's more.
- hash_next  input  1  core pulse: block absorbed, ready for the next chained block.
- hash_done  input  1  core out_valid: digest produced.
- blk_cnt  output  16  blocks emitted for the current message.
- pad_err  output  1  sticky error flag (see Optional Feature).

Behaviour:
- Block layout: block byte k at blk_data[8k+7:8k]; message word j fills bytes 8j..8j+7.
- Reset (rst=1 at a clock edge): all outputs 0, buffer cleared, word counter 0, state FILL.
  - in_ready rises to 1 in the first cycle after rst deasserts.
  - Reset mid-message or mid-wait discards all progress. Core handshakes seen during reset are ignored.
- States: FILL, SEND, WAIT_NEXT, WAIT_DONE, PADBLK.
- FILL: in_ready=1. A word is accepted on in_valid&in_ready and written at word counter wcnt (0..RATE_WORDS-1).
  - Non-last word, wcnt<RATE_WORDS-1: wcnt++.
  - Non-last word, wcnt=RATE_WORDS-1: block complete; go to SEND with more=1.
  - Last word, in_bytes<8: bytes >= in_bytes are zeroed. Byte in_bytes of that word = DOMAIN. All later words are 0. Block byte RATE_BYTES-1 is ORed with 8'h80 (giving 8'h86 if it coincides with the DOMAIN byte). Go to SEND with more=0.
  - Last word, in_bytes=8, wcnt<RATE_WORDS-1: DOMAIN goes at byte 0 of word wcnt+1; byte RATE_BYTES-1 |= 8'h80. Go to SEND with more=0.
  - Last word, in_bytes=8, wcnt=RATE_WORDS-1: go to SEND with more=1 and set pad_pending.
  - in_bytes=0 with in_last=1 (empty tail) is legal: the word's data is ignored and DOMAIN lands at byte 0 of word wcnt.
- SEND: blk_valid=1 for exactly one cycle; in_ready=0. blk_data/blk_more are stable from SEND until the next SEND. blk_cnt++.
  - Next state: WAIT_NEXT if more=1, else WAIT_DONE.
- WAIT_NEXT: in_ready=0. On hash_next=1: go to PADBLK if pad_pending, else FILL with wcnt=0 and the buffer cleared.
- PADBLK (one cycle): buffer = DOMAIN at byte 0, 8'h80 at byte RATE_BYTES-1, zeros elsewhere; clear pad_pending; go to SEND with more=0.
- WAIT_DONE: in_ready=0. On hash_done=1: go to FILL, clear buffer and wcnt, blk_cnt=0.
- hash_next or hash_done asserted in the SEND cycle itself is ignored. hash_next in WAIT_DONE and hash_done in WAIT_NEXT are ignored.
- Latency: from the accepting edge of the block-completing word, blk_valid rises on the next cycle.
- Never more than one block is outstanding at the core.

Optional Feature:
- Macro SHA3_PAD_CHECK_EN.
- Defined:
  - in_last=1 with in_bytes>8 sets pad_err, and the word is treated as in_bytes=8.
  - in_valid=1 while in_ready=0 also sets pad_err; the word is dropped.
  - pad_err is cleared only by rst.
- Undefined: pad_err tied to 0; in_bytes>8 behaviour is unspecified; no checking logic is present.

Test Plan:
- Empty message (single word, in_last=1, in_bytes=0) -> one block: byte0=8'h06, byte135=8'h80, all else 0; blk_more=0; blk_cnt=1.
- "abc" (in_data=64'h636261, in_bytes=3, last) -> bytes 0..3 = 61 62 63 06, byte135=80, rest 0, more=0; in_ready stays 0 until hash_done, then returns to 1.
- 135-byte message (16 full words + last word with in_bytes=7) -> single block with byte135=8'h86, more=0.
- 136-byte message (17 full words, last with in_bytes=8):
  - first block carries the data, more=1;
  - no second blk_valid until hash_next;
  - one cycle after hash_next, PADBLK runs and the next cycle outputs the pad block 06..80 with more=0; blk_cnt=2.
- 200-byte message with in_valid held high -> in_ready drops after word 17; block 1 has more=1; after hash_next the remaining 8 words are accepted; block 2 has DOMAIN at byte 64 and more=0.
- Assert rst after 5 words accepted -> all outputs 0; a subsequent "abc" message produces exactly the "abc" block above, with no residue from the aborted words.

Source files
------------

// File: rtl/sha3_padder_if.sv
// Message-word and block handshake bundle between the SHA-3 padder, its feeder and the core.
interface sha3_padder_if #(
  parameter int unsigned RATE_BYTES = 136
);
  logic [63:0]             in_data;
  logic                    in_valid;
  logic                    in_last;
  logic [3:0]              in_bytes;
  logic                    in_ready;
  logic [8*RATE_BYTES-1:0] blk_data;
  logic                    blk_valid;
  logic                    blk_more;
  logic                    hash_next;
  logic                    hash_done;
  logic [15:0]             blk_cnt;
  logic                    pad_err;

  // Message source plus core-side responder.
  modport master (
    output in_data, in_valid, in_last, in_bytes, hash_next, hash_done,
    input  in_ready, blk_data, blk_valid, blk_more, blk_cnt, pad_err
  );

  // The padder itself.
  modport slave (
    input  in_data, in_valid, in_last, in_bytes, hash_next, hash_done,
    output in_ready, blk_data, blk_valid, blk_more, blk_cnt, pad_err
  );
endinterface

// File: rtl/sha3_padder.sv
// SHA-3 pad10*1 padder: packs 64-bit message words into rate blocks and paces them into the core.
// Define SHA3_PAD_CHECK_EN to add the sticky pad_err protocol checker.
module sha3_padder #(
  parameter int unsigned RATE_BYTES = 136,
  parameter logic [7:0]  DOMAIN     = 8'h06
) (
  input logic          clk,
  input logic          rst,
  sha3_padder_if.slave bus
);

  localparam int unsigned RATE_WORDS = RATE_BYTES / 8;
  localparam int unsigned WcntW      = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam int unsigned BlkW       = 8 * RATE_BYTES;

  typedef enum logic [2:0] {
    StFill,
    StSend,
    StWaitNext,
    StWaitDone,
    StPadBlk
  } state_e;

  state_e            state_q;
  logic [WcntW-1:0]  wcnt_q;
  logic [BlkW-1:0]   buf_q;
  logic [BlkW-1:0]   blk_data_q;
  logic              blk_valid_q;
  logic              blk_more_q;
  logic [15:0]       blk_cnt_q;
  logic              pad_pend_q;
  logic              in_ready_q;

  logic [3:0]        nbytes;
  logic              full_tail;
  logic              last_slot;
  logic [63:0]       word;
  logic [BlkW-1:0]   fill_blk;
  logic [BlkW-1:0]   pad_blk;
  logic              fill_done;
  logic              fill_more;
  logic              fill_pend;

  always_comb begin
`ifdef SHA3_PAD_CHECK_EN
    // An oversized tail count is clamped to a full word.
    nbytes = (bus.in_last && (bus.in_bytes > 4'd8)) ? 4'd8 : bus.in_bytes;
`else
    nbytes = bus.in_bytes;
`endif
    full_tail = nbytes[3];
    last_slot = (wcnt_q == WcntW'(RATE_WORDS - 1));

    word = bus.in_data;
    if (bus.in_last && !full_tail) begin
      for (int b = 0; b < 8; b++) begin
        if (b >= int'(nbytes)) begin
          word[8*b +: 8] = (b == int'(nbytes)) ? DOMAIN : 8'h00;
        end
      end
    end

    fill_blk = buf_q;
    fill_blk[64*wcnt_q +: 64] = word;
    if (bus.in_last && full_tail && !last_slot) begin
      fill_blk[64*(int'(wcnt_q) + 1) +: 8] = DOMAIN;
    end
    // OR rather than overwrite so a domain byte in the last slot becomes 8'h86.
    if (bus.in_last && !(full_tail && last_slot)) begin
      fill_blk[BlkW-1 -: 8] = fill_blk[BlkW-1 -: 8] | 8'h80;
    end

    fill_done = bus.in_last || last_slot;
    fill_pend = bus.in_last && full_tail && last_slot;
    fill_more = !bus.in_last || fill_pend;

    pad_blk          = '0;
    pad_blk[7:0]     = DOMAIN;
    pad_blk[BlkW-1 -: 8] = pad_blk[BlkW-1 -: 8] | 8'h80;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      wcnt_q      <= '0;
      buf_q       <= '0;
      blk_data_q  <= '0;
      blk_valid_q <= 1'b0;
      blk_more_q  <= 1'b0;
      blk_cnt_q   <= '0;
      pad_pend_q  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      blk_valid_q <= 1'b0;
      unique case (state_q)
        StFill: begin
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (bus.in_valid) begin
            buf_q <= fill_blk;
            if (fill_done) begin
              blk_data_q  <= fill_blk;
              blk_more_q  <= fill_more;
              pad_pend_q  <= fill_pend;
              blk_valid_q <= 1'b1;
              blk_cnt_q   <= blk_cnt_q + 16'd1;
              in_ready_q  <= 1'b0;
              state_q     <= StSend;
            end else begin
              wcnt_q <= wcnt_q + WcntW'(1);
            end
          end
        end
        StSend: begin
          // Core handshakes in this cycle belong to no block yet and are dropped.
          state_q <= blk_more_q ? StWaitNext : StWaitDone;
        end
        StWaitNext: begin
          if (bus.hash_next) begin
            if (pad_pend_q) begin
              state_q <= StPadBlk;
            end else begin
              state_q    <= StFill;
              wcnt_q     <= '0;
              buf_q      <= '0;
              in_ready_q <= 1'b1;
            end
          end
        end
        StPadBlk: begin
          buf_q       <= pad_blk;
          blk_data_q  <= pad_blk;
          blk_more_q  <= 1'b0;
          pad_pend_q  <= 1'b0;
          blk_valid_q <= 1'b1;
          blk_cnt_q   <= blk_cnt_q + 16'd1;
          state_q     <= StSend;
        end
        StWaitDone: begin
          if (bus.hash_done) begin
            state_q    <= StFill;
            wcnt_q     <= '0;
            buf_q      <= '0;
            blk_cnt_q  <= '0;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

`ifdef SHA3_PAD_CHECK_EN
  logic pad_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_err_q <= 1'b0;
    end else if (bus.in_valid &&
                 (!in_ready_q || (bus.in_last && (bus.in_bytes > 4'd8)))) begin
      pad_err_q <= 1'b1;
    end
  end

  assign bus.pad_err = pad_err_q;
`else
  assign bus.pad_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.blk_data  = blk_data_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_more  = blk_more_q;
  assign bus.blk_cnt   = blk_cnt_q;

endmodule
